// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter and sequencer that shares one ALU between
// N_REQ requesters. A winner is granted, its operands are driven to the ALU,
// and the result comes back as a one-cycle rsp_valid pulse to that requester.
// No-op opcodes complete after a single start cycle. The reset opcode pulses
// the ALU's active-low reset for RST_CYCLES cycles.
// Optional feature: define ALU_ARB_TIMEOUT_EN to abort a WAIT that sees no
// alu_done within TIMEOUT cycles. The abort resets the ALU and answers with
// rsp_err=1.
module alu_arbiter #(
  parameter int         N_REQ      = 4,
  parameter logic [2:0] NOP_OPC    = 3'b000,
  parameter logic [2:0] RST_OPC    = 3'b111,
  parameter int         RST_CYCLES = 2,
  parameter int         TIMEOUT    = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_a,
  input  logic [8*N_REQ-1:0]   req_b,
  input  logic [3*N_REQ-1:0]   req_op,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     rsp_valid,
  output logic [15:0]          rsp_result,
  output logic                 rsp_err,
  output logic                 busy,
  output logic [7:0]           alu_a,
  output logic [7:0]           alu_b,
  output logic [2:0]           alu_op,
  output logic                 alu_start,
  output logic                 alu_rst_n,
  input  logic                 alu_done,
  input  logic [15:0]          alu_result
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + RST_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, WAIT, NOP, ARST} state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   win_q;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;
  logic            found;
  logic [CW-1:0]   cnt;

  logic [7:0]      a_arr  [N_REQ];
  logic [7:0]      b_arr  [N_REQ];
  logic [2:0]      op_arr [N_REQ];

`ifdef ALU_ARB_TIMEOUT_EN
  logic            abort_q;
`endif

  function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] idx);
    onehot = '0;
    onehot[idx] = 1'b1;
  endfunction

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign a_arr[g]  = req_a[8*g +: 8];
    assign b_arr[g]  = req_b[8*g +: 8];
    assign op_arr[g] = req_op[3*g +: 3];
  end

  // Rotating search: first active request after the last winner, with wrap
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = ptr;
    for (int i = 0; i < N_REQ; i++) begin
      cand = (cand == IW'(N_REQ - 1)) ? '0 : cand + 1'b1;
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Sequencer FSM: grant, drive the ALU, wait or count, then respond
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= IW'(N_REQ - 1);
      win_q      <= '0;
      cnt        <= '0;
      gnt        <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      busy       <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= NOP_OPC;
      alu_start  <= 1'b0;
      alu_rst_n  <= 1'b0;
`ifdef ALU_ARB_TIMEOUT_EN
      abort_q    <= 1'b0;
      rsp_err    <= 1'b0;
`endif
    end else begin
      gnt       <= '0;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          alu_rst_n <= 1'b1;
          if (found) begin
            ptr    <= win_idx;
            win_q  <= win_idx;
            gnt    <= onehot(win_idx);
            alu_a  <= a_arr[win_idx];
            alu_b  <= b_arr[win_idx];
            alu_op <= op_arr[win_idx];
            busy   <= 1'b1;
            cnt    <= '0;
`ifdef ALU_ARB_TIMEOUT_EN
            abort_q <= 1'b0;
`endif
            if (op_arr[win_idx] == RST_OPC) begin
              state     <= ARST;
              alu_rst_n <= 1'b0;
              alu_start <= 1'b0;
            end else if (op_arr[win_idx] == NOP_OPC) begin
              state     <= NOP;
              alu_start <= 1'b1;
            end else begin
              state     <= WAIT;
              alu_start <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (alu_done) begin
            alu_start  <= 1'b0;
            rsp_result <= alu_result;
            rsp_valid  <= onehot(win_q);
            busy       <= 1'b0;
            state      <= IDLE;
`ifdef ALU_ARB_TIMEOUT_EN
            rsp_err    <= 1'b0;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            // Hung ALU: drop start and reuse the reset sequence to recover it
            alu_start <= 1'b0;
            alu_rst_n <= 1'b0;
            abort_q   <= 1'b1;
            cnt       <= '0;
            state     <= ARST;
          end else begin
            cnt <= cnt + 1'b1;
`endif
          end
        end
        NOP: begin
          alu_start  <= 1'b0;
          rsp_result <= alu_result;
          rsp_valid  <= onehot(win_q);
          busy       <= 1'b0;
          state      <= IDLE;
`ifdef ALU_ARB_TIMEOUT_EN
          rsp_err    <= 1'b0;
`endif
        end
        ARST: begin
          if (cnt == CW'(RST_CYCLES - 1)) begin
            alu_rst_n  <= 1'b1;
            rsp_result <= '0;
            rsp_valid  <= onehot(win_q);
            busy       <= 1'b0;
            state      <= IDLE;
`ifdef ALU_ARB_TIMEOUT_EN
            rsp_err    <= abort_q;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef ALU_ARB_TIMEOUT_EN
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: behavioural ALU, requester models, and
// scoreboards for grants and responses.
module tb_alu_arbiter;

  localparam int N = 4;
  localparam logic [2:0] ADD = 3'b001;
  localparam logic [2:0] MUL = 3'b011;
  localparam logic [2:0] NOPC = 3'b000;
  localparam logic [2:0] RSTC = 3'b111;

  typedef struct packed {
    logic [3:0]  vld;
    logic [15:0] res;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [7:0] op_a [N];
  logic [7:0] op_b [N];
  logic [2:0] op_c [N];
  logic [8*N-1:0] req_a, req_b;
  logic [3*N-1:0] req_op;
  logic [N-1:0] gnt, rsp_valid;
  logic [15:0] rsp_result;
  logic rsp_err, busy;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_op;
  logic alu_start, alu_rst_n;
  logic alu_done = 1'b0;
  logic [15:0] alu_result = '0;

  int n_checks = 0;
  int n_fail = 0;
  exp_t sb[$];
  int gexp[$];
  int rem [N];
  int start_hi, rstn_lo, rsp_cnt;
  logic [N-1:0] first_gnt;
  logic prev_start = 1'b0;

  int lat = 1;
  bit stuck = 1'b0;
  int acnt = 0;

  assign req_a  = {op_a[3], op_a[2], op_a[1], op_a[0]};
  assign req_b  = {op_b[3], op_b[2], op_b[1], op_b[0]};
  assign req_op = {op_c[3], op_c[2], op_c[1], op_c[0]};

  alu_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .req_op(req_op), .gnt(gnt), .rsp_valid(rsp_valid),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_rst_n(alu_rst_n), .alu_done(alu_done), .alu_result(alu_result)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                        input logic [2:0] op);
    case (op)
      ADD:     alu_f = 16'(a) + 16'(b);
      MUL:     alu_f = 16'(a) * 16'(b);
      default: alu_f = {a, b};
    endcase
  endfunction

  // Behavioural ALU: done pulses lat cycles after start is seen
  always @(posedge clk) begin
    alu_done <= 1'b0;
    if (alu_start && !alu_done && !stuck) begin
      if (acnt >= lat - 1) begin
        alu_done   <= 1'b1;
        alu_result <= alu_f(alu_a, alu_b, alu_op);
        acnt       <= 0;
      end else begin
        acnt <= acnt + 1;
      end
    end else begin
      acnt <= 0;
    end
  end

  // Response scoreboard
  always @(negedge clk) begin
    if (rsp_valid != '0) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: got vld=%b res=%h err=%b, required no response",
                 rsp_valid, rsp_result, rsp_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({rsp_valid, rsp_result, rsp_err} !== e) begin
          n_fail++;
          $display("FAIL rsp: got vld=%b res=%h err=%b, required vld=%b res=%h err=%b",
                   rsp_valid, rsp_result, rsp_err, e.vld, e.res, e.err);
        end
      end
    end
  end

  // Grant scoreboard: order, captured operands, start/reset behaviour
  always @(negedge clk) begin
    if (gnt != '0) begin
      n_checks++;
      if (gexp.size() == 0) begin
        n_fail++;
        $display("FAIL gnt_unexpected: got gnt=%b, required none", gnt);
      end else begin
        int w;
        logic [N-1:0] eg;
        logic es, er;
        w  = gexp.pop_front();
        eg = '0;
        eg[w] = 1'b1;
        es = (op_c[w] == RSTC) ? 1'b0 : 1'b1;
        er = (op_c[w] == RSTC) ? 1'b0 : 1'b1;
        if ({gnt, alu_a, alu_b, alu_op, alu_start, alu_rst_n, busy, prev_start} !==
            {eg, op_a[w], op_b[w], op_c[w], es, er, 1'b1, 1'b0}) begin
          n_fail++;
          $display("FAIL gnt: got gnt=%b a=%h b=%h op=%b st=%b rn=%b busy=%b prev_st=%b, required gnt=%b a=%h b=%h op=%b st=%b rn=%b busy=1 prev_st=0",
                   gnt, alu_a, alu_b, alu_op, alu_start, alu_rst_n, busy, prev_start,
                   eg, op_a[w], op_b[w], op_c[w], es, er);
        end
      end
    end
    prev_start <= alu_start;
  end

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op);
    op_a[i] = a;
    op_b[i] = b;
    op_c[i] = op;
  endtask

  // Requester model: holds req until granted rem[i] times, gathers statistics
  task automatic run_ops(input int max_cyc);
    int c;
    bit first;
    start_hi = 0; rstn_lo = 0; rsp_cnt = 0; first = 1'b1; c = 0;
    forever begin
      @(negedge clk);
      c++;
      if (first) begin first_gnt = gnt; first = 1'b0; end
      if (alu_start) start_hi++;
      if (!alu_rst_n) rstn_lo++;
      if (rsp_valid != '0) rsp_cnt++;
      for (int i = 0; i < N; i++) if (gnt[i] && rem[i] > 0) rem[i]--;
      for (int i = 0; i < N; i++) req[i] = (rem[i] != 0);
      if (req == '0 && !busy) break;
      if (c >= max_cyc) break;
    end
    n_checks++;
    if (c >= max_cyc) begin
      n_fail++;
      $display("FAIL run_timeout: got %0d cycles without idle, required fewer than %0d", c, max_cyc);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++) begin
      set_req(i, 8'(i + 1), 8'h02, ADD);
      rem[i] = 0;
    end
    rem[0] = 1;
    req = '1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({gnt, rsp_valid, rsp_result, rsp_err, busy, alu_a, alu_b, alu_op, alu_start, alu_rst_n} !==
          {4'b0, 4'b0, 16'h0, 1'b0, 1'b0, 8'h0, 8'h0, 3'b000, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL reset_state: got gnt=%b vld=%b res=%h err=%b busy=%b a=%h b=%h op=%b st=%b rn=%b, required all zero, op=000",
                 gnt, rsp_valid, rsp_result, rsp_err, busy, alu_a, alu_b, alu_op, alu_start, alu_rst_n);
      end
    end
    gexp.push_back(0);
    sb.push_back('{4'b0001, 16'h0003, 1'b0});
    rst = 1'b0;
    run_ops(50);
    n_checks++;
    if (first_gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL first_gnt: got %b, required 0001", first_gnt);
    end
  endtask

  task automatic test_add();
    lat = 1;
    set_req(2, 8'h12, 8'h34, ADD);
    rem[2] = 1;
    gexp.push_back(2);
    sb.push_back('{4'b0100, 16'h0046, 1'b0});
    req[2] = 1'b1;
    run_ops(50);
    n_checks++;
    if (start_hi !== 2 || rsp_cnt !== 1) begin
      n_fail++;
      $display("FAIL add_timing: got start_cycles=%0d rsp=%0d, required 2 and 1", start_hi, rsp_cnt);
    end
  endtask

  task automatic test_rst_op();
    set_req(3, 8'hAA, 8'h55, RSTC);
    rem[3] = 1;
    gexp.push_back(3);
    sb.push_back('{4'b1000, 16'h0000, 1'b0});
    req[3] = 1'b1;
    run_ops(50);
    n_checks++;
    if (rstn_lo !== 2 || start_hi !== 0) begin
      n_fail++;
      $display("FAIL rst_op: got rstn_low=%0d start_cycles=%0d, required 2 and 0", rstn_lo, start_hi);
    end
  endtask

  task automatic test_round_robin();
    int order [3];
    order = '{0, 1, 3};
    lat = 3;
    for (int k = 0; k < 3; k++) begin
      set_req(order[k], 8'(8'h11 * (order[k] + 1)), 8'(8'h05 + order[k]), MUL);
      rem[order[k]] = 2;
    end
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 3; k++) begin
        logic [3:0] v;
        v = '0;
        v[order[k]] = 1'b1;
        gexp.push_back(order[k]);
        sb.push_back('{v, 16'(op_a[order[k]]) * 16'(op_b[order[k]]), 1'b0});
      end
    req = 4'b1011;
    run_ops(200);
    n_checks++;
    if (rsp_cnt !== 6 || start_hi !== 24) begin
      n_fail++;
      $display("FAIL rr_timing: got rsp=%0d start_cycles=%0d, required 6 and 24", rsp_cnt, start_hi);
    end
  endtask

  task automatic test_nop();
    lat = 1;
    set_req(1, 8'h01, 8'h02, NOPC);
    rem[1] = 1;
    gexp.push_back(1);
    sb.push_back('{4'b0010, alu_result, 1'b0});
    req[1] = 1'b1;
    run_ops(50);
    n_checks++;
    if (start_hi !== 1 || rsp_cnt !== 1) begin
      n_fail++;
      $display("FAIL nop_timing: got start_cycles=%0d rsp=%0d, required 1 and 1", start_hi, rsp_cnt);
    end
  endtask

`ifdef ALU_ARB_TIMEOUT_EN
  task automatic test_timeout();
    stuck = 1'b1;
    set_req(0, 8'h05, 8'h06, ADD);
    rem[0] = 1;
    gexp.push_back(0);
    sb.push_back('{4'b0001, 16'h0000, 1'b1});
    req[0] = 1'b1;
    run_ops(300);
    stuck = 1'b0;
    n_checks++;
    if (start_hi !== 64 || rstn_lo !== 2 || rsp_cnt !== 1) begin
      n_fail++;
      $display("FAIL timeout: got start_cycles=%0d rstn_low=%0d rsp=%0d, required 64, 2 and 1",
               start_hi, rstn_lo, rsp_cnt);
    end
  endtask
`endif

  task automatic test_rst_mid_wait();
    int cnt;
    stuck = 1'b1;
    set_req(1, 8'h07, 8'h08, ADD);
    gexp.push_back(1);
    req[1] = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (gnt[1]) req[1] = 1'b0;
    end
    n_checks++;
    if (busy !== 1'b1 || alu_start !== 1'b1) begin
      n_fail++;
      $display("FAIL stuck_wait: got busy=%b start=%b, required 1 and 1", busy, alu_start);
    end
`ifndef ALU_ARB_TIMEOUT_EN
    repeat (200) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_forever: got busy=%b, required 1", busy);
    end
`endif
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, gnt, rsp_valid, alu_start, alu_rst_n, alu_op} !== {1'b0, 4'b0, 4'b0, 1'b0, 1'b0, 3'b000}) begin
      n_fail++;
      $display("FAIL mid_reset: got busy=%b gnt=%b vld=%b st=%b rn=%b op=%b, required all zero",
               busy, gnt, rsp_valid, alu_start, alu_rst_n, alu_op);
    end
    rst = 1'b0;
    stuck = 1'b0;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid != '0 || gnt != '0) cnt++;
    end
    n_checks++;
    if (cnt !== 0 || sb.size() !== 0 || gexp.size() !== 0) begin
      n_fail++;
      $display("FAIL after_reset: got activity=%0d pending_rsp=%0d pending_gnt=%0d, required 0 0 0",
               cnt, sb.size(), gexp.size());
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_rst_op();
    test_round_robin();
    test_nop();
`ifdef ALU_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_rst_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
